// File: rtl/ok_uart_reporter_if.sv
`default_nettype none
// ============================================================================
// Module      : ok_uart_reporter_if
// Description : OK flag / result bus feeding the UART reporter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ok_uart_reporter_if;
    logic       ok;
    logic [6:0] ok_data;

    modport master (output ok, output ok_data);
    modport slave  (input  ok, input  ok_data);
endinterface
`default_nettype wire

// File: rtl/ok_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module      : ok_uart_reporter
// Description : Captures ok_data on each OK rising edge into a FIFO and
//               serialises the buffered results as UART 8N1 frames.
// Revision    : 1.0 - initial release
// ============================================================================
module ok_uart_reporter #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic                    i_clk,
    input  wire logic                    i_rst,
    ok_uart_reporter_if.slave            ok_bus,
    output logic                         o_tx,
    output logic                         o_busy,
    output logic [$clog2(DEPTH):0]       o_fifo_count,
    output logic                         o_overflow
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam int c_baud_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic                ok_q;
    logic [6:0]          mem_q [DEPTH];
    logic [c_addr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_addr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic                ovf_q, ovf_d;

    state_t              state_q, state_d;
    logic [c_baud_w-1:0] baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;

    logic w_capture;
    logic w_wr_en;
    logic w_pop;
    logic w_baud_last;

    // Full check uses the pre-cycle count, so a same-cycle pop never frees a slot.
    assign w_capture   = ok_bus.ok & ~ok_q;
    assign w_wr_en     = w_capture & (count_q < c_depth);
    assign w_baud_last = (baud_q == c_baud_last);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + c_addr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_addr_w'(1);
        end
        if (w_wr_en && !w_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (!w_wr_en && w_pop) begin
            count_d = count_q - c_cnt_w'(1);
        end
        if (w_capture && !w_wr_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_rst) begin
            mem_q[wr_ptr_q] <= ok_bus.ok_data;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (count_q != '0) begin
                    w_pop   = 1'b1;
                    shift_d = {1'b1, mem_q[rd_ptr_q]};
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + c_baud_w'(1);
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + c_baud_w'(1);
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + c_baud_w'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ok_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            ok_q     <= ok_bus.ok;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_fifo_count = count_q;
    assign o_overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ok_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ok_uart_reporter
// Description : Directed scoreboard bench; a UART monitor decodes frames and
//               compares them against expected bytes queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ok_uart_reporter;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx;
    logic       busy;
    logic [2:0] cnt;
    logic       ovf;

    ok_uart_reporter_if ok_bus ();

    ok_uart_reporter #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .ok_bus       (ok_bus.slave),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_fifo_count (cnt),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         frames    = 0;
    logic [7:0] sb[$];
    int         starts[$];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame monitor: samples mid-bit on the falling edge.
    initial begin
        logic [7:0] rx;
        int         busy_n;
        bit         aborted;
        logic       start_b;
        logic       stop_b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                starts.push_back(cyc);
                rx = '0; busy_n = 0; aborted = 1'b0; start_b = 1'b1; stop_b = 1'b0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (busy === 1'b1) busy_n++;
                    if (c == CPB / 2) start_b = tx;
                    if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2) rx[c / CPB - 1] = tx;
                    if (c == 9 * CPB + CPB / 2) stop_b = tx;
                end
                if (!aborted) begin
                    @(negedge clk);
                    check("start_bit", int'(start_b), 0);
                    check("stop_bit", int'(stop_b), 1);
                    check("busy_len", busy_n, FRAME);
                    check("idle_after_frame", int'({busy, tx}), 1);
                    check("frame_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) check("frame_byte", int'(rx), int'(sb.pop_front()));
                    frames++;
                end
            end
        end
    end

    initial begin
        int f0;
        int s0;
        int peak;
        int ce[6] = '{1, 1, 2, 3, 4, 4};

        ok_bus.ok = 1'b0;
        ok_bus.ok_data = '0;
        rst = 1'b1;
        tick(3);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(cnt), 0);
        check("rst_overflow", int'(ovf), 0);
        rst = 1'b0;
        tick(2);

        // Single capture and latency
        f0 = frames;
        ok_bus.ok = 1'b1; ok_bus.ok_data = 7'h55; sb.push_back(8'hD5);
        tick(1);
        ok_bus.ok = 1'b0;
        check("s1_count_n1", int'(cnt), 1);
        check("s1_tx_n1", int'(tx), 1);
        tick(1);
        check("s1_tx_n2", int'(tx), 0);
        check("s1_busy_n2", int'(busy), 1);
        check("s1_count_n2", int'(cnt), 0);
        tick(FRAME + 10);
        check("s1_frames", frames - f0, 1);

        // Held level
        f0 = frames; peak = 0;
        ok_bus.ok = 1'b1; ok_bus.ok_data = 7'h0A; sb.push_back(8'h8A);
        repeat (200) begin
            tick(1);
            if (int'(cnt) > peak) peak = int'(cnt);
        end
        ok_bus.ok = 1'b0;
        tick(FRAME + 10);
        check("s2_peak_count", peak, 1);
        check("s2_frames", frames - f0, 1);

        // Burst ordering with back-to-back frames
        f0 = frames; s0 = starts.size();
        for (int k = 1; k <= 3; k++) begin
            ok_bus.ok = 1'b1; ok_bus.ok_data = 7'(k); sb.push_back({1'b1, 7'(k)});
            tick(1);
            ok_bus.ok = 1'b0;
            tick(1);
        end
        tick(3 * (FRAME + 1) + 10);
        check("s3_frames", frames - f0, 3);
        check("s3_starts", starts.size() - s0, 3);
        if (starts.size() >= s0 + 3) begin
            check("s3_gap1", starts[s0 + 1] - starts[s0], FRAME + 1);
            check("s3_gap2", starts[s0 + 2] - starts[s0 + 1], FRAME + 1);
        end
        check("s3_overflow", int'(ovf), 0);

        // Overflow: sixth capture dropped
        f0 = frames;
        for (int k = 0; k < 6; k++) begin
            ok_bus.ok = 1'b1; ok_bus.ok_data = 7'(k + 1);
            if (k < 5) sb.push_back({1'b1, 7'(k + 1)});
            tick(1);
            ok_bus.ok = 1'b0;
            check($sformatf("s4_count_%0d", k + 1), int'(cnt), ce[k]);
            check($sformatf("s4_overflow_%0d", k + 1), int'(ovf), (k == 5) ? 1 : 0);
            tick(1);
        end
        tick(5 * (FRAME + 1) + 20);
        check("s4_frames", frames - f0, 5);
        check("s4_overflow_sticky", int'(ovf), 1);
        check("s4_count_drained", int'(cnt), 0);

        // Reset during DATA bit 3 with a second entry queued
        f0 = frames;
        ok_bus.ok = 1'b1; ok_bus.ok_data = 7'h2A;
        tick(1);
        ok_bus.ok = 1'b0;
        tick(1);
        ok_bus.ok = 1'b1; ok_bus.ok_data = 7'h2B;
        tick(1);
        ok_bus.ok = 1'b0;
        tick(16);
        check("s5_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("s5_tx", int'(tx), 1);
        check("s5_busy", int'(busy), 0);
        check("s5_count", int'(cnt), 0);
        check("s5_overflow", int'(ovf), 0);
        tick(100);
        check("s5_no_frames", frames - f0, 0);
        ok_bus.ok = 1'b1; ok_bus.ok_data = 7'h2C; sb.push_back(8'hAC);
        tick(1);
        ok_bus.ok = 1'b0;
        tick(FRAME + 10);
        check("s5_frame_after_edge", frames - f0, 1);

        // Pointer wrap-around
        f0 = frames;
        for (int k = 0; k < 10; k++) begin
            ok_bus.ok = 1'b1; ok_bus.ok_data = 7'(8'h10 + k);
            sb.push_back({1'b1, 7'(8'h10 + k)});
            tick(1);
            ok_bus.ok = 1'b0;
            tick(FRAME + 5);
        end
        check("s6_frames", frames - f0, 10);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ok_uart_reporter.md
# ok_uart_reporter

Downstream consumer of the top-level `ok` / `ok_data` result pair. Each rising edge of the OK flag captures the accompanying 7-bit result into a small FIFO. The buffered results are then serialised out on a single UART 8N1 transmit line, so results can be observed on hardware without a logic analyser. Results are never lost silently: if they arrive faster than the UART drains them, a sticky overflow flag is raised.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.

Ports:
- `i_clk`, input, 1: system clock; all logic on rising edge.
- `i_rst`, input, 1: reset; one clock, synchronous and active-high.
- `i_ok`, input, 1: OK status level from the upstream stage.
- `i_ok_data`, input, 7: result value; valid in the cycle `i_ok` rises.
- `o_tx`, output, 1: UART serial out; idles high.
- `o_busy`, output, 1: high while a frame is on the line (START/DATA/STOP).
- `o_fifo_count`, output, $clog2(DEPTH)+1: entries currently buffered.
- `o_overflow`, output, 1: sticky; a capture was dropped because the FIFO was full.

## Operation
**Edge detect**
- Register `ok_q` holds the previous value of `i_ok`.
- A capture occurs in any cycle with `i_ok=1 && ok_q=0`.
- A held level produces exactly one capture. A new capture requires `i_ok` to return to 0 for at least one cycle.

**FIFO**
- Circular buffer, `DEPTH` entries × 7 bits, with wrap-around read/write pointers and an explicit count.
- Write: on a capture, if the count sampled at the start of the cycle is less than `DEPTH`.
- Full behaviour: a capture while full is dropped (FIFO contents unchanged) and `o_overflow` is set to 1. It stays 1 until reset.
- Full + pop in the same cycle: the capture is still dropped. Only the pre-cycle count is used for the full check.
- Empty + capture in the same cycle: the entry is written; the pop happens no earlier than the next cycle.
- Simultaneous write and pop: the count is unchanged.

**Transmit FSM** (states IDLE, START, DATA, STOP)
- IDLE
  - `o_tx=1`.
  - If count > 0: pop the head entry and load an 8-bit shift register with `{1'b1, data[6:0]}`. Bit 7 = 1 marks the frame as a result.
  - Then go to START.
- START: `o_tx=0` for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA
  - 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles.
  - A bit counter runs 0..7; after bit 7, go to STOP.
- STOP: `o_tx=1` for `CLKS_PER_BIT` cycles, then go to IDLE.
- IDLE always lasts at least one cycle between frames.
- `o_busy=1` in START, DATA and STOP.

**Reset**
- Reset clears: pointers, count, `ok_q`, FSM state (→ IDLE), bit/baud counters and `o_overflow`.
- Reset mid-frame aborts the frame; `o_tx` returns high on the next edge.
- A capture in the reset cycle is ignored.

## Timing
**Reset values**
- `o_tx=1`, `o_busy=0`, `o_fifo_count=0`, `o_overflow=0`.
- `ok_q=0`. Therefore an `i_ok` that is already high when reset releases counts as a rising edge.

**Latency**
- Capture edge at cycle N:
  - `o_fifo_count` increments at N+1.
  - The FSM pops at N+1 if it is IDLE.
  - `o_tx` falls and `o_busy` rises at N+2.
- Frame length: exactly `10*CLKS_PER_BIT` cycles of `o_busy=1`.
- Back-to-back frames are separated by exactly 1 IDLE cycle (`o_tx=1`, `o_busy=0`).

**Other rules**
- The baud counter counts 0..`CLKS_PER_BIT`-1 and restarts on every state/bit change.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and `DEPTH=4`.

1. **Single capture.** Pulse `i_ok` for 1 cycle with `i_ok_data=7'h55`.
   - Required: `o_tx` goes low 2 cycles after the edge.
   - Required bit sequence (4 cycles each): start 0, then data 1,0,1,0,1,0,1,1 (byte 8'hD5 LSB first), then stop 1.
   - Required: `o_busy` high for exactly 40 cycles.
2. **Held level.** Hold `i_ok=1` for 200 cycles with data 7'h0A.
   - Required: exactly one frame, byte 8'h8A.
   - Required: `o_fifo_count` peaks at 1.
3. **Burst ordering.** Send 3 one-cycle pulses 2 cycles apart with data 7'h01, 7'h02, 7'h03.
   - Required: frames with bytes 8'h81, 8'h82, 8'h83, in order.
   - Required: a 1-cycle idle gap between frames.
   - Required: `o_overflow` stays 0.
4. **Overflow.** Send 6 pulses 2 cycles apart (data 1..6) while the first frame is in flight.
   - Required: `o_fifo_count` reaches 4.
   - Required: `o_overflow` rises on the 6th capture. The 5th is accepted, because the first entry was already popped.
   - Required: exactly 5 frames, data 1..5.
   - Required: `o_overflow` is still 1 after the FIFO drains.
5. **Reset mid-frame.** Assert `i_rst` for 1 cycle during DATA bit 3.
   - Required: next cycle `o_tx=1`, `o_busy=0`, `o_fifo_count=0`, `o_overflow=0`.
   - Required: no further frames until a new `i_ok` edge arrives.
6. **Pointer wrap-around.** Send 10 spaced single captures, each waiting for frame completion, with data 7'h10..7'h19.
   - Required: all 10 frames are correct and in order across the pointer wrap.
